// File: rtl/sat_meas_loader.sv
// Collects four satellite measurement records into parallel slots for the
// solver, holding en high until the solver finishes, a watchdog fires, or a flush.
module sat_meas_loader #(
  parameter int W    = 40,
  parameter int FRAC = 8,
  parameter int TMO  = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [5:0]   in_id_i,
  input  logic [W-1:0] in_x_i,
  input  logic [W-1:0] in_y_i,
  input  logic [W-1:0] in_z_i,
  input  logic [W-1:0] in_r_i,
  input  logic [W-1:0] in_bias_i,
  input  logic         flush_i,
  input  logic         solver_done_i,
  output logic [W-1:0] x1_o, x2_o, x3_o, x4_o,
  output logic [W-1:0] y1_o, y2_o, y3_o, y4_o,
  output logic [W-1:0] z1_o, z2_o, z3_o, z4_o,
  output logic [W-1:0] r1_o, r2_o, r3_o, r4_o,
  output logic         en_o,
  output logic         busy_o,
  output logic [2:0]   slot_cnt_o,
  output logic         err_rej_o,
  output logic         err_sat_o,
  output logic         err_tmo_o
);

  typedef enum logic {FILL, RUN} state_t;

  localparam int WdW = $clog2(TMO + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TMO - 1);
  localparam logic [W-1:0] RMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] RMin = {1'b1, {(W-1){1'b0}}};

  // FRAC only documents the fixed-point format of the words passing through.
  if (FRAC >= W) begin : g_frac_wider_than_word
  end

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [5:0]     prn_q [4];
  logic [5:0]     prn_d [4];
  logic [W-1:0]   xs_q [4];
  logic [W-1:0]   xs_d [4];
  logic [W-1:0]   ys_q [4];
  logic [W-1:0]   ys_d [4];
  logic [W-1:0]   zs_q [4];
  logic [W-1:0]   zs_d [4];
  logic [W-1:0]   rs_q [4];
  logic [W-1:0]   rs_d [4];
  logic           rej_q, rej_d, sat_q, sat_d, tmo_q, tmo_d;

  logic           accept, dup, badId, satHit;
  logic [W:0]     rSum;
  logic [W-1:0]   rCorr;

  assign in_ready_o = (state_q == FILL) && !flush_i && !rst_i;
  assign accept     = in_valid_i && in_ready_o;

  // Sign-extended sum overflows exactly when its top two bits disagree.
  always_comb begin
    rSum   = {in_r_i[W-1], in_r_i} + {in_bias_i[W-1], in_bias_i};
    satHit = rSum[W] != rSum[W-1];
    rCorr  = rSum[W-1:0];
    if (satHit) rCorr = rSum[W] ? RMin : RMax;
  end

  always_comb begin
    badId = (in_id_i == 6'd0) || (in_id_i > 6'd32);
    dup   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < cnt_q) && (prn_q[i] == in_id_i)) dup = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    prn_d   = prn_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    zs_d    = zs_q;
    rs_d    = rs_q;
    rej_d   = 1'b0;
    sat_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (flush_i) begin
          cnt_d = 3'd0;
        end else if (accept) begin
          if (badId || dup) begin
            rej_d = 1'b1;
          end else begin
            prn_d[cnt_q[1:0]] = in_id_i;
            xs_d[cnt_q[1:0]]  = in_x_i;
            ys_d[cnt_q[1:0]]  = in_y_i;
            zs_d[cnt_q[1:0]]  = in_z_i;
            rs_d[cnt_q[1:0]]  = rCorr;
            sat_d = satHit;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              state_d = RUN;
              wd_d    = '0;
            end
          end
        end
      end
      RUN: begin
        // Flush and done both beat the watchdog and leave silently.
        if (flush_i || solver_done_i) begin
          state_d = FILL;
          cnt_d   = 3'd0;
        end else if (wd_q == WdLast) begin
          state_d = FILL;
          cnt_d   = 3'd0;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= 3'd0;
      wd_q    <= '0;
      rej_q   <= 1'b0;
      sat_q   <= 1'b0;
      tmo_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        prn_q[i] <= 6'd0;
        xs_q[i]  <= '0;
        ys_q[i]  <= '0;
        zs_q[i]  <= '0;
        rs_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      rej_q   <= rej_d;
      sat_q   <= sat_d;
      tmo_q   <= tmo_d;
      prn_q   <= prn_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      zs_q    <= zs_d;
      rs_q    <= rs_d;
    end
  end

  assign en_o       = (state_q == RUN);
  assign busy_o     = (state_q == RUN);
  assign slot_cnt_o = cnt_q;
  assign err_rej_o  = rej_q;
  assign err_sat_o  = sat_q;
  assign err_tmo_o  = tmo_q;

  assign x1_o = xs_q[0];
  assign x2_o = xs_q[1];
  assign x3_o = xs_q[2];
  assign x4_o = xs_q[3];
  assign y1_o = ys_q[0];
  assign y2_o = ys_q[1];
  assign y3_o = ys_q[2];
  assign y4_o = ys_q[3];
  assign z1_o = zs_q[0];
  assign z2_o = zs_q[1];
  assign z3_o = zs_q[2];
  assign z4_o = zs_q[3];
  assign r1_o = rs_q[0];
  assign r2_o = rs_q[1];
  assign r3_o = rs_q[2];
  assign r4_o = rs_q[3];

endmodule

// File: tb/tb_sat_meas_loader.sv
// Directed bench for sat_meas_loader: a vector table for single-cycle behaviour
// plus hand-written sequences for watchdog, flush-in-RUN and reset-in-RUN.
module tb_sat_meas_loader;

  localparam int W = 40;
  localparam int TMO = 64;

  typedef struct {
    logic         valid;
    logic [5:0]   id;
    logic [W-1:0] r;
    logic [W-1:0] bias;
    logic         flush;
    logic         done;
    logic         expReady;
    logic [2:0]   expCnt;
    logic         expEn;
    logic         expRej;
    logic         expSat;
    logic         expTmo;
    int           slot;
    logic [W-1:0] expR;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, inValid, inReady, flush, solverDone;
  logic [5:0]   inId;
  logic [W-1:0] inX, inY, inZ, inR, inBias;
  logic [W-1:0] x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4, r1, r2, r3, r4;
  logic         en, busy, errRej, errSat, errTmo;
  logic [2:0]   slotCnt;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  localparam logic [W-1:0] R1 = 40'd5940402819;
  localparam logic [W-1:0] R2 = 40'd5525973855;
  localparam logic [W-1:0] R3 = 40'd8029250563;
  localparam logic [W-1:0] R4 = 40'd6391500475;
  localparam logic [W-1:0] RMaxV = 40'h7F_FFFF_FFFF;
  localparam logic [W-1:0] RMinV = 40'h80_0000_0000;
  localparam logic [W-1:0] NearMax = 40'h7F_FFFF_FF00;
  localparam logic [W-1:0] NearMin = 40'h80_0000_000A;
  localparam logic [W-1:0] Z40 = 40'd0;

  sat_meas_loader #(.W(W), .FRAC(8), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady),
    .in_id_i(inId), .in_x_i(inX), .in_y_i(inY), .in_z_i(inZ), .in_r_i(inR),
    .in_bias_i(inBias), .flush_i(flush), .solver_done_i(solverDone),
    .x1_o(x1), .x2_o(x2), .x3_o(x3), .x4_o(x4),
    .y1_o(y1), .y2_o(y2), .y3_o(y3), .y4_o(y4),
    .z1_o(z1), .z2_o(z2), .z3_o(z3), .z4_o(z4),
    .r1_o(r1), .r2_o(r2), .r3_o(r3), .r4_o(r4),
    .en_o(en), .busy_o(busy), .slot_cnt_o(slotCnt),
    .err_rej_o(errRej), .err_sat_o(errSat), .err_tmo_o(errTmo)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] slotR(input int k);
    case (k)
      0: return r1;
      1: return r2;
      2: return r3;
      default: return r4;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic addVec(input logic valid, input logic [5:0] id, input logic [W-1:0] r,
                        input logic [W-1:0] bias, input logic fl, input logic dn,
                        input logic eReady, input logic [2:0] eCnt, input logic eEn,
                        input logic eRej, input logic eSat, input int slot,
                        input logic [W-1:0] eR);
    vec_t v;
    v.valid = valid; v.id = id; v.r = r; v.bias = bias; v.flush = fl; v.done = dn;
    v.expReady = eReady; v.expCnt = eCnt; v.expEn = eEn; v.expRej = eRej;
    v.expSat = eSat; v.expTmo = 1'b0; v.slot = slot; v.expR = eR;
    vecs.push_back(v);
  endtask

  // Drive one vector, check the combinational ready, then clock and check state.
  task automatic applyStimulus(input vec_t v, input int idx);
    inValid = v.valid; inId = v.id; inR = v.r; inBias = v.bias;
    inX = v.r + 40'd1; inY = v.r + 40'd2; inZ = v.r + 40'd3;
    flush = v.flush; solverDone = v.done;
    #1;
    checkOutput($sformatf("v%0d ready", idx), {39'd0, inReady}, {39'd0, v.expReady});
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d cnt", idx), {37'd0, slotCnt}, {37'd0, v.expCnt});
    checkOutput($sformatf("v%0d en", idx), {39'd0, en}, {39'd0, v.expEn});
    checkOutput($sformatf("v%0d busy", idx), {39'd0, busy}, {39'd0, v.expEn});
    checkOutput($sformatf("v%0d rej", idx), {39'd0, errRej}, {39'd0, v.expRej});
    checkOutput($sformatf("v%0d sat", idx), {39'd0, errSat}, {39'd0, v.expSat});
    checkOutput($sformatf("v%0d tmo", idx), {39'd0, errTmo}, {39'd0, v.expTmo});
    checkOutput($sformatf("v%0d slot%0d r", idx, v.slot + 1), slotR(v.slot), v.expR);
  endtask

  task automatic idleInputs();
    inValid = 1'b0; inId = 6'd0; inX = Z40; inY = Z40; inZ = Z40; inR = Z40;
    inBias = Z40; flush = 1'b0; solverDone = 1'b0;
  endtask

  // Load PRNs 1..4 back to back: x=7k, y=11k, z=13k, r=10k.
  task automatic fillSet();
    for (int k = 1; k <= 4; k++) begin
      inValid = 1'b1; inId = 6'(k);
      inX = 40'(7 * k); inY = 40'(11 * k); inZ = 40'(13 * k); inR = 40'(10 * k);
      inBias = Z40;
      @(posedge clk); #1;
    end
    idleInputs();
  endtask

  initial begin
    int enCycles;
    int tmoPulses;
    idleInputs();
    rst = 1'b1;

    // Nominal set, then done five cycles after the 4th accept
    addVec(1'b1, 6'd3,  R1, Z40, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 0, R1);
    addVec(1'b1, 6'd7,  R2, Z40, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1, R2);
    addVec(1'b1, 6'd12, R3, Z40, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 2, R3);
    addVec(1'b1, 6'd19, R4, Z40, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3, R4);
    for (int i = 0; i < 4; i++)
      addVec(1'b0, 6'd0, Z40, Z40, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 0, R1);
    addVec(1'b0, 6'd0, Z40, Z40, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, R2);
    addVec(1'b0, 6'd0, Z40, Z40, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3, R4);
    // Saturation both ways, then a flush that must not take the offered record
    addVec(1'b1, 6'd5, NearMax, 40'd512, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 0, RMaxV);
    addVec(1'b1, 6'd6, NearMin, -40'sd20, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1, RMinV);
    addVec(1'b1, 6'd9, 40'd555, Z40, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2, R3);
    // Rejection of duplicate, zero and out-of-range PRNs
    addVec(1'b1, 6'd3,  40'd3000, Z40, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 0, 40'd3000);
    addVec(1'b1, 6'd7,  40'd7000, Z40, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1, 40'd7000);
    addVec(1'b1, 6'd3,  40'd3333, Z40, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 2, R3);
    addVec(1'b1, 6'd0,  40'd1,    Z40, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 2, R3);
    addVec(1'b1, 6'd33, 40'd2,    Z40, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 2, R3);
    addVec(1'b1, 6'd9,  40'd100, -40'sd30, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 2, 40'd70);
    addVec(1'b1, 6'd12, 40'd12000, Z40, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3, 40'd12000);
    // Inputs wiggling during RUN leave slots frozen; done in FILL is ignored
    addVec(1'b1, 6'd20, 40'd999, 40'd5, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 3, 40'd12000);
    addVec(1'b1, 6'd21, 40'd888, Z40,   1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 0, 40'd3000);
    addVec(1'b0, 6'd0,  Z40,     Z40,   1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2, 40'd70);
    addVec(1'b1, 6'd4,  40'd4000, Z40,  1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 0, 40'd4000);
    addVec(1'b0, 6'd0,  Z40,     Z40,   1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 40'd4000);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset cnt", {37'd0, slotCnt}, 40'd0);
    checkOutput("reset en", {39'd0, en}, 40'd0);
    checkOutput("reset ready", {39'd0, inReady}, 40'd0);
    checkOutput("reset r1", r1, Z40);
    rst = 1'b0;
    #1;
    checkOutput("ready after reset", {39'd0, inReady}, 40'd1);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
    idleInputs();

    // Watchdog: en high exactly TMO cycles, one err_tmo in first FILL cycle
    fillSet();
    enCycles = 0;
    tmoPulses = 0;
    while (en && enCycles < 4 * TMO) begin
      enCycles++;
      @(posedge clk); #1;
      if (errTmo) tmoPulses++;
    end
    checkOutput("wd en cycles", 40'(enCycles), 40'(TMO));
    checkOutput("wd tmo now", {39'd0, errTmo}, 40'd1);
    checkOutput("wd ready", {39'd0, inReady}, 40'd1);
    checkOutput("wd cnt", {37'd0, slotCnt}, 40'd0);
    @(posedge clk); #1;
    if (errTmo) tmoPulses++;
    checkOutput("wd tmo pulses", 40'(tmoPulses), 40'd1);

    // Done on the last watchdog cycle wins
    fillSet();
    repeat (TMO - 1) @(posedge clk);
    #1;
    checkOutput("late en", {39'd0, en}, 40'd1);
    solverDone = 1'b1;
    @(posedge clk); #1;
    solverDone = 1'b0;
    checkOutput("late done en", {39'd0, en}, 40'd0);
    checkOutput("late done tmo", {39'd0, errTmo}, 40'd0);
    checkOutput("late done cnt", {37'd0, slotCnt}, 40'd0);

    // Flush in RUN aborts quietly
    fillSet();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush run en", {39'd0, en}, 40'd0);
    checkOutput("flush run cnt", {37'd0, slotCnt}, 40'd0);
    checkOutput("flush run tmo", {39'd0, errTmo}, 40'd0);
    checkOutput("flush run ready", {39'd0, inReady}, 40'd0);
    flush = 1'b0;
    #1;
    checkOutput("post flush ready", {39'd0, inReady}, 40'd1);

    // Reset mid-RUN clears everything on the next edge
    fillSet();
    checkOutput("fill x4", x4, 40'd28);
    checkOutput("fill y2", y2, 40'd22);
    checkOutput("fill z3", z3, 40'd39);
    checkOutput("fill r1", r1, 40'd10);
    checkOutput("fill en", {39'd0, en}, 40'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst run en", {39'd0, en}, 40'd0);
    checkOutput("rst run cnt", {37'd0, slotCnt}, 40'd0);
    checkOutput("rst run x4", x4, Z40);
    checkOutput("rst run r1", r1, Z40);
    checkOutput("rst run tmo", {39'd0, errTmo}, 40'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sat_meas_loader.md
# sat_meas_loader

Upstream stage of `linear_solver`: collects four satellite measurement records (PRN, ECEF position, raw pseudorange, clock-bias correction), one per handshake. It applies the bias correction with saturation, rejects invalid or duplicate PRNs, and presents the set in parallel on `x1..x4 / y1..y4 / z1..z4 / r1..r4`. It then holds `en` high until the solver reports `done` or a watchdog expires, and only then accepts the next set.

## Interface

**Parameters**
- `W`, 40: signed two's-complement width of every coordinate and range word, in metres, Q(W-FRAC).FRAC.
- `FRAC`, 8: fractional bits. Informational only; no arithmetic depends on it.
- `TMO`, 64: maximum cycles `en` stays high waiting for `solver_done`.

**Ports**
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: record present.
- `in_ready` output 1: loader accepts a record this cycle.
- `in_id` input 6: satellite PRN; valid range 1..32.
- `in_x`, `in_y`, `in_z` input W: satellite ECEF position.
- `in_r` input W: raw pseudorange.
- `in_bias` input W: signed correction added to `in_r`.
- `flush` input 1: discard the current set and abort any solve.
- `solver_done` input 1: solver result valid.
- `x1..x4`, `y1..y4`, `z1..z4`, `r1..r4` output W each: slot k carries the k-th accepted record.
- `en` output 1: solver enable.
- `busy` output 1: high in RUN.
- `slot_cnt` output 3: records held in the current set, 0..4.
- `err_rej` output 1: one-cycle pulse when a record is dropped (PRN 0, PRN > 32, or PRN already in the current set).
- `err_sat` output 1: one-cycle pulse when a corrected range is clamped.
- `err_tmo` output 1: one-cycle pulse on watchdog expiry.

## Operation

- **States:** FILL and RUN. Reset enters FILL with `slot_cnt`=0.
- **Handshake:** a transfer occurs on a rising edge where `in_valid && in_ready`.
  - `in_ready = (state==FILL) && !flush && !rst`.
  - `in_ready` must not depend on `in_valid`.
- **Acceptance in FILL:**
  - If `in_id` is invalid or matches a stored PRN with index < `slot_cnt`: the record is consumed and dropped, `err_rej` pulses next cycle, and `slot_cnt` is unchanged.
  - Otherwise the record is written to slot `slot_cnt`, and `slot_cnt` increments.
- **Range correction:** the sum `in_r + in_bias` is formed at W+1 bits.
  - If the sum is > 2^(W-1)-1, the slot gets 2^(W-1)-1.
  - If the sum is < -2^(W-1), the slot gets -2^(W-1).
  - In either clamp case `err_sat` pulses. The record is still stored.
- **Set complete:** when the 4th record is stored, the state goes to RUN and the watchdog counter clears.
- **RUN:**
  - `en`=1 and `busy`=1.
  - All slot outputs are frozen.
  - `solver_done` is ignored in FILL.
- **Exit from RUN:**
  - `solver_done`=1 sampled in RUN: go to FILL with `slot_cnt`=0.
  - Otherwise the counter increments. When it reaches TMO: go to FILL with `slot_cnt`=0, and `err_tmo` pulses.
  - If `solver_done` arrives in the same cycle as the TMO expiry, done wins and there is no `err_tmo`.
- **flush:**
  - In FILL: `slot_cnt`←0.
  - In RUN: abort to FILL with `slot_cnt`←0 and no error pulse.
  - `flush` has priority over a simultaneous handshake and over `solver_done`.
- **Slot outputs** retain their last values after returning to FILL. Stale slots at index ≥ `slot_cnt` are don't-care for the solver.
- **Reset:**
  - All slot outputs, `en`, `busy`, `slot_cnt`, and the error pulses go to 0.
  - Stored PRNs clear and the state goes to FILL.
  - Reset mid-RUN drops `en` on the next edge, with no `err_tmo`.

## Timing

- **Record latency:** a record accepted at edge t is visible on its slot outputs and in `slot_cnt` after edge t; `err_rej`/`err_sat` are high in cycle t+1 only.
- **4th accept:** at edge t gives `en`=1, `busy`=1, and `in_ready`=0 from cycle t+1.
- **Done:** `solver_done` sampled high at edge u gives `en`=0 and `in_ready`=1 from cycle u+1. The next set may begin at edge u+1.
- **Watchdog:** `en` stays high for at most TMO consecutive cycles. `err_tmo` is high in the first FILL cycle.
- **Throughput:** minimum 4 cycles per set plus RUN duration. There are no bubbles while `in_valid` is held high in FILL.

## Test plan

1. **Nominal set:** reset for 2 cycles, then four back-to-back records with PRNs 3, 7, 12, 19, bias 0, and ranges 23204698.51, 21585835.37, 31364260.01, 24966798.73 ×2^8 → `r1..r4` equal those words. `en` rises the cycle after the 4th accept. `solver_done` asserted 5 cycles later → `en` falls next cycle and `slot_cnt`=0.
2. **Saturation:** `in_r`=2^39-256, `in_bias`=512 → slot = 2^39-1 and one `err_sat` pulse. `in_r`=-2^39+10, `in_bias`=-20 → slot = -2^39 and a pulse.
3. **Rejection:** PRNs 3, 7, 3, 0, 33, 9, 12 → three `err_rej` pulses. Slots hold 3, 7, 9, 12. `en` rises after the PRN 12 accept.
4. **Watchdog:** complete a set and never assert `solver_done` → `en` is high exactly 64 cycles, `err_tmo` pulses once, then `in_ready`=1. Done arriving on cycle 64 → no `err_tmo`.
5. **Flush and reset:**
   - Flush after 2 records → `slot_cnt`=0 and the record offered in the flush cycle is not accepted.
   - Flush in RUN → `en` low next cycle, no error pulse.
   - `rst` mid-RUN → all outputs 0 next cycle.
6. **Frozen outputs:** toggle `in_valid` and the data inputs during RUN → slot outputs unchanged and no handshake occurs.
